// File: rtl/i2c_bus_decoder_if.sv
// I2C decode-stage bus bundle: filtered line inputs and
// registered protocol strobes toward the formatter.
interface i2c_bus_decoder_if;
   logic       i_scl;
   logic       i_sda;
   logic       o_start;
   logic       o_rstart;
   logic       o_stop;
   logic       o_byte_valid;
   logic [7:0] o_data;
   logic       o_ack;
   logic       o_addr_byte;
   logic       o_abort;
   logic       o_timeout;
   logic       o_busy;

   modport master (
      output i_scl, i_sda,
      input  o_start, o_rstart, o_stop, o_byte_valid,
      input  o_data, o_ack, o_addr_byte,
      input  o_abort, o_timeout, o_busy
   );

   modport slave (
      input  i_scl, i_sda,
      output o_start, o_rstart, o_stop, o_byte_valid,
      output o_data, o_ack, o_addr_byte,
      output o_abort, o_timeout, o_busy
   );
endinterface

// File: rtl/i2c_bus_decoder.sv
// Passive I2C protocol decoder: START/Sr/STOP detection,
// byte + ACK assembly and an idle-SCL watchdog.
module i2c_bus_decoder #(
   parameter int TIMEOUT_NUM = 270000,
   parameter int TIMEOUT_BIT = 19
) (
   input logic              i_clk,
   input logic              i_res,
   i2c_bus_decoder_if.slave bus
);
   localparam logic [0:0] ST_IDLE   = 1'b0;
   localparam logic [0:0] ST_ACTIVE = 1'b1;
   localparam logic [TIMEOUT_BIT-1:0] TO_LAST =
      TIMEOUT_BIT'(TIMEOUT_NUM - 1);
   localparam logic [TIMEOUT_BIT-1:0] TO_MAX = '1;
   localparam bit TO_EN = (TIMEOUT_NUM != 0);

   logic [0:0]             state;
   logic                   scl_d;
   logic                   sda_d;
   logic [3:0]             bit_cnt;
   logic [7:0]             shift;
   logic [TIMEOUT_BIT-1:0] to_cnt;
   logic                   first;

   logic       start_r;
   logic       rstart_r;
   logic       stop_r;
   logic       valid_r;
   logic [7:0] data_r;
   logic       ack_r;
   logic       addr_r;
   logic       abort_r;
   logic       timeout_r;

   logic cond_start;
   logic cond_stop;
   logic cond_rise;
   logic partial;

   assign cond_start = scl_d & bus.i_scl & sda_d & ~bus.i_sda;
   assign cond_stop  = scl_d & bus.i_scl & ~sda_d & bus.i_sda;
   assign cond_rise  = ~scl_d & bus.i_scl;
   assign partial    = (bit_cnt != 4'd0);

   assign bus.o_start      = start_r;
   assign bus.o_rstart     = rstart_r;
   assign bus.o_stop       = stop_r;
   assign bus.o_byte_valid = valid_r;
   assign bus.o_data       = data_r;
   assign bus.o_ack        = ack_r;
   assign bus.o_addr_byte  = addr_r;
   assign bus.o_abort      = abort_r;
   assign bus.o_timeout    = timeout_r;
   assign bus.o_busy       = (state == ST_ACTIVE);

   // Line history, protocol state machine and registered strobes
   always_ff @(posedge i_clk) begin
      if (i_res) begin
         scl_d     <= 1'b1;
         sda_d     <= 1'b1;
         state     <= ST_IDLE;
         bit_cnt   <= 4'd0;
         shift     <= 8'd0;
         to_cnt    <= '0;
         first     <= 1'b0;
         start_r   <= 1'b0;
         rstart_r  <= 1'b0;
         stop_r    <= 1'b0;
         valid_r   <= 1'b0;
         data_r    <= 8'd0;
         ack_r     <= 1'b0;
         addr_r    <= 1'b0;
         abort_r   <= 1'b0;
         timeout_r <= 1'b0;
      end else begin
         scl_d     <= bus.i_scl;
         sda_d     <= bus.i_sda;
         start_r   <= 1'b0;
         rstart_r  <= 1'b0;
         stop_r    <= 1'b0;
         valid_r   <= 1'b0;
         abort_r   <= 1'b0;
         timeout_r <= 1'b0;
         unique case (state)
            ST_IDLE: begin
               to_cnt <= '0;
               if (cond_start) begin
                  state   <= ST_ACTIVE;
                  start_r <= 1'b1;
                  bit_cnt <= 4'd0;
                  first   <= 1'b1;
               end else if (cond_stop) begin
                  stop_r <= 1'b1;
               end
            end
            ST_ACTIVE: begin
               if (cond_start) begin
                  to_cnt   <= '0;
                  rstart_r <= 1'b1;
                  abort_r  <= partial;
                  bit_cnt  <= 4'd0;
                  first    <= 1'b1;
               end else if (cond_stop) begin
                  to_cnt  <= '0;
                  stop_r  <= 1'b1;
                  abort_r <= partial;
                  state   <= ST_IDLE;
                  bit_cnt <= 4'd0;
               end else if (cond_rise) begin
                  to_cnt <= '0;
                  if (bit_cnt == 4'd8) begin
                     data_r  <= shift;
                     ack_r   <= ~bus.i_sda;
                     addr_r  <= first;
                     valid_r <= 1'b1;
                     first   <= 1'b0;
                     bit_cnt <= 4'd0;
                  end else begin
                     shift   <= {shift[6:0], bus.i_sda};
                     bit_cnt <= bit_cnt + 4'd1;
                  end
               end else if (TO_EN && to_cnt == TO_LAST) begin
                  to_cnt    <= '0;
                  timeout_r <= 1'b1;
                  abort_r   <= partial;
                  state     <= ST_IDLE;
                  bit_cnt   <= 4'd0;
               end else if (to_cnt != TO_MAX) begin
                  to_cnt <= to_cnt + 1'b1;
               end
            end
         endcase
      end
   end
endmodule

// File: tb/tb_i2c_bus_decoder.sv
// Scoreboard bench for i2c_bus_decoder: semantic bus driver,
// transaction-level model feeding a queue, decoupled monitor.
module tb_i2c_bus_decoder;
   localparam int TO_NUM = 16;
   localparam int K_Q    = 0;
   localparam int K_R    = 1;
   localparam int K_S    = 2;
   localparam int K_P    = 3;
   localparam int K_RST  = 4;

   typedef struct packed {
      logic       start;
      logic       rstart;
      logic       stop;
      logic       bv;
      logic [7:0] data;
      logic       ack;
      logic       addr;
      logic       abort;
      logic       timeout;
   } ev_t;

   logic clk;
   logic res;
   i2c_bus_decoder_if bus();

   i2c_bus_decoder #(
      .TIMEOUT_NUM(TO_NUM),
      .TIMEOUT_BIT(5)
   ) dut (
      .i_clk(clk),
      .i_res(res),
      .bus  (bus)
   );

   int  cyc = 0;
   int  checks = 0;
   int  failures = 0;
   ev_t exp_q[$];
   int  stamp_q[$];

   bit m_active = 0;
   int m_bits = 0;
   int m_val = 0;
   int m_idle = 0;
   bit m_first = 0;
   int h_data = 0;
   bit h_ack = 0;
   bit h_addr = 0;
   bit cur_scl = 1;
   bit cur_sda = 1;

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   // Sample index of the most recent rising edge
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #600000;
      $display("FAIL watchdog cyc=%0d limit reached", cyc);
      $fatal(1);
   end

   // Reference: act on the protocol meaning of each bus sample
   function void model(int k, bit d, int stamp);
      ev_t e;
      bit  fire;
      e = '0;
      fire = 0;
      case (k)
         K_Q: begin
            if (m_active) begin
               m_idle++;
               if (m_idle == TO_NUM) begin
                  e.timeout = 1;
                  e.abort = (m_bits != 0);
                  m_active = 0;
                  m_bits = 0;
                  fire = 1;
               end
            end
         end
         K_R: begin
            m_idle = 0;
            if (m_active) begin
               if (m_bits == 8) begin
                  h_data = m_val;
                  h_ack = !d;
                  h_addr = m_first;
                  m_first = 0;
                  m_bits = 0;
                  e.bv = 1;
                  fire = 1;
               end else begin
                  m_val = (m_val * 2 + int'(d)) % 256;
                  m_bits++;
               end
            end
         end
         K_S: begin
            m_idle = 0;
            if (m_active) begin
               e.rstart = 1;
               e.abort = (m_bits != 0);
            end else begin
               e.start = 1;
            end
            m_active = 1;
            m_bits = 0;
            m_first = 1;
            fire = 1;
         end
         K_P: begin
            m_idle = 0;
            e.stop = 1;
            e.abort = m_active && (m_bits != 0);
            m_active = 0;
            m_bits = 0;
            fire = 1;
         end
         default: begin
            m_active = 0;
            m_bits = 0;
            m_val = 0;
            m_idle = 0;
            m_first = 0;
            h_data = 0;
            h_ack = 0;
            h_addr = 0;
         end
      endcase
      if (fire) begin
         e.data = 8'(h_data);
         e.ack = h_ack;
         e.addr = h_addr;
         exp_q.push_back(e);
         stamp_q.push_back(stamp);
      end
   endfunction

   task automatic check(string name, int act, int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s got=%0d want=%0d", name, act, exp);
      end
   endtask

   task automatic step(bit s, bit d, int k);
      bus.i_scl = s;
      bus.i_sda = d;
      cur_scl = s;
      cur_sda = d;
      model(k, d, cyc + 1);
      @(negedge clk);
   endtask

   task automatic send_bit(bit b, bit comb);
      if (cur_scl) step(0, cur_sda, K_Q);
      if (!comb) step(0, b, K_Q);
      step(1, b, K_R);
      step(1, b, K_Q);
   endtask

   task automatic send_bits(int v, int n, bit comb);
      for (int i = n - 1; i >= 0; i--) send_bit(v[i], comb);
   endtask

   task automatic send_byte(int v, bit ack_low, bit comb);
      send_bits(v, 8, comb);
      send_bit(!ack_low, comb);
   endtask

   task automatic do_start();
      if (cur_scl && cur_sda) begin
         step(1, 0, K_S);
      end else begin
         if (cur_scl) step(0, cur_sda, K_Q);
         step(0, 1, K_Q);
         step(1, 1, K_R);
         step(1, 0, K_S);
      end
   endtask

   task automatic do_stop();
      if (cur_scl && !cur_sda) begin
         step(1, 1, K_P);
      end else begin
         if (cur_scl) step(0, cur_sda, K_Q);
         step(0, 0, K_Q);
         step(1, 0, K_R);
         step(1, 1, K_P);
      end
   endtask

   task automatic hold(int n);
      for (int i = 0; i < n; i++) step(cur_scl, cur_sda, K_Q);
   endtask

   task automatic hold_low(int n);
      for (int i = 0; i < n; i++) step(0, cur_sda, K_Q);
   endtask

   task automatic rst_step();
      if (cur_scl) step(0, cur_sda, K_Q);
      res = 1;
      model(K_RST, 0, cyc + 1);
      @(negedge clk);
      res = 0;
      step(0, cur_sda, K_Q);
   endtask

   // Monitor: pop and compare whenever an expected or actual strobe lands
   always @(negedge clk) begin
      ev_t act;
      ev_t exp;
      bit  pulse;
      act = {bus.o_start, bus.o_rstart, bus.o_stop,
             bus.o_byte_valid, bus.o_data, bus.o_ack,
             bus.o_addr_byte, bus.o_abort, bus.o_timeout};
      pulse = bus.o_start | bus.o_rstart | bus.o_stop |
              bus.o_byte_valid | bus.o_abort | bus.o_timeout;
      while (stamp_q.size() > 0 && stamp_q[0] < cyc) begin
         checks++;
         failures++;
         $display("FAIL missed_event cyc=%0d got=none want=%h",
                  stamp_q[0], exp_q[0]);
         void'(stamp_q.pop_front());
         void'(exp_q.pop_front());
      end
      if (stamp_q.size() > 0 && stamp_q[0] == cyc) begin
         void'(stamp_q.pop_front());
         exp = exp_q.pop_front();
         checks++;
         if (act !== exp) begin
            failures++;
            $display("FAIL event cyc=%0d got=%h want=%h",
                     cyc, act, exp);
         end
      end else if (pulse) begin
         checks++;
         failures++;
         $display("FAIL spurious cyc=%0d got=%h want=none",
                  cyc, act);
      end
   end

   initial begin
      int op;
      bus.i_scl = 1;
      bus.i_sda = 1;
      res = 1;
      repeat (3) @(negedge clk);
      check("rst_pulses",
            {bus.o_start, bus.o_rstart, bus.o_stop,
             bus.o_byte_valid, bus.o_abort, bus.o_timeout}, 0);
      check("rst_data", bus.o_data, 0);
      check("rst_flags", {bus.o_ack, bus.o_addr_byte}, 0);
      check("rst_busy", bus.o_busy, 0);
      res = 0;
      hold(2);

      do_start();
      send_byte(8'hA0, 1, 0);
      do_stop();
      hold(3);
      check("t1_busy", bus.o_busy, m_active);
      check("t1_data", bus.o_data, 8'hA0);

      do_start();
      send_byte(8'h90, 1, 0);
      send_byte(8'h5A, 0, 1);
      do_stop();
      hold(3);
      check("t2_ack", bus.o_ack, 0);

      do_start();
      send_byte(8'hA0, 1, 0);
      do_start();
      send_byte(8'hA1, 1, 0);
      do_stop();
      hold(3);
      check("t3_addr", bus.o_addr_byte, 1);

      do_start();
      send_bits(3'b101, 3, 0);
      do_stop();
      hold(3);
      check("t4_busy", bus.o_busy, 0);

      do_start();
      send_bits(2'b10, 2, 0);
      hold_low(20);
      check("t5_busy", bus.o_busy, 0);
      do_start();
      do_stop();
      hold(3);

      do_start();
      send_bits(4'b1100, 4, 0);
      hold_low(1);
      rst_step();
      send_bit(1, 0);
      check("t6_data", bus.o_data, h_data);
      check("t6_busy", bus.o_busy, 0);
      hold(2);
      do_start();
      send_byte(8'h3C, 1, 0);
      do_stop();
      hold(3);
      check("t6_byte", bus.o_data, 8'h3C);

      for (int it = 0; it < 80; it++) begin
         op = $urandom_range(0, 9);
         case (op)
            0, 1: do_start();
            2, 3, 4: send_byte($urandom_range(0, 255),
                               1'($urandom_range(0, 1)),
                               1'($urandom_range(0, 1)));
            5: send_bits($urandom_range(0, 127),
                         $urandom_range(1, 7),
                         1'($urandom_range(0, 1)));
            6, 7: do_stop();
            8: hold_low($urandom_range(12, 20));
            default: begin
               if ($urandom_range(0, 3) == 0) rst_step();
               else hold($urandom_range(1, 4));
            end
         endcase
      end
      do_stop();
      hold(5);
      check("end_busy", bus.o_busy, m_active);
      check("end_data", bus.o_data, h_data);
      check("drain", stamp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
